pipe_skid_stage: RTL and testbench

//   Generic, parametrised pipeline boundary register. It is the successor to the fixed-field
//   IF/ID register and is used for every stage boundary (IF/ID, ID/EX, EX/MEM, MEM/WB).
//   - Payload is one opaque DATA_W bus, carried under a valid/ready handshake.
//   - 2-entry skid buffer: full throughput, and in_ready_o is a pure register output
//     (no combinational ready path back up the pipeline).
//   - Synchronous flush squashes every entry held in the stage.
//

---
 rtl/pipe_skid_stage.sv | 105 ++++++++++
 tb/tb_pipe_skid_stage.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_stage.sv
// Generic pipeline boundary register with a 2-entry skid buffer and synchronous flush.
// Define PIPE_SKID_STATS_EN to add saturating stall/flush statistics counters.
module pipe_skid_stage #(
  parameter int                DATA_W    = 96,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
`ifdef PIPE_SKID_STATS_EN
  ,
  parameter int                CNT_W     = 32
`endif
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o
`ifdef PIPE_SKID_STATS_EN
  ,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_p0;
  logic [DATA_W-1:0] main_p0;
  logic [DATA_W-1:0] skid_p0;
  logic              in_fire;
  logic              out_fire;

  assign in_fire    = in_valid_i & in_ready_o;
  assign out_fire   = out_valid_o & out_ready_i;
  assign out_data_o = main_p0;

  // Stage boundary: main register feeds downstream, skid catches the beat accepted while stalled.
  always_ff @(posedge clk) begin
    if (rst || flush_i) begin
      state_p0    <= EMPTY;
      out_valid_o <= 1'b0;
      in_ready_o  <= 1'b1;
      main_p0     <= RESET_VAL;
      skid_p0     <= RESET_VAL;
    end else begin
      case (state_p0)
        EMPTY: begin
          if (in_fire) begin
            state_p0    <= BUSY;
            main_p0     <= in_data_i;
            out_valid_o <= 1'b1;
          end
        end
        BUSY: begin
          if (in_fire && out_fire) begin
            main_p0 <= in_data_i;
          end else if (in_fire) begin
            state_p0   <= FULL;
            skid_p0    <= in_data_i;
            in_ready_o <= 1'b0;
          end else if (out_fire) begin
            state_p0    <= EMPTY;
            out_valid_o <= 1'b0;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_p0   <= BUSY;
            main_p0    <= skid_p0;
            in_ready_o <= 1'b1;
          end
        end
        default: begin
          state_p0    <= EMPTY;
          out_valid_o <= 1'b0;
          in_ready_o  <= 1'b1;
        end
      endcase
    end
  end

`ifdef PIPE_SKID_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  // Counters survive flush; only rst clears them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_o <= '0;
      flush_cnt_o <= '0;
    end else begin
      if (out_valid_o && !out_ready_i) stall_cnt_o <= sat_inc(stall_cnt_o);
      if (flush_i && (state_p0 != EMPTY)) flush_cnt_o <= sat_inc(flush_cnt_o);
    end
  end
`endif

endmodule

// File: tb/tb_pipe_skid_stage.sv
// Self-checking bench for pipe_skid_stage: directed scenarios then randomized traffic
// against a queue-based occupancy model.
module tb_pipe_skid_stage;
  localparam int                DW      = 32;
  localparam logic [DW-1:0]     RV      = 32'hDEAD0000;
  localparam int                CW      = 4;
  localparam int                CNT_MAX = (1 << CW) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          flush_i = 1'b0;
  logic          in_valid_i = 1'b0;
  logic          in_ready_o;
  logic [DW-1:0] in_data_i = '0;
  logic          out_valid_o;
  logic          out_ready_i = 1'b0;
  logic [DW-1:0] out_data_o;
`ifdef PIPE_SKID_STATS_EN
  logic [CW-1:0] stall_cnt_o;
  logic [CW-1:0] flush_cnt_o;
`endif

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] q[$];
  logic [DW-1:0] head_m = RV;
  int            stall_m = 0;
  int            flush_m = 0;

  pipe_skid_stage #(
    .DATA_W    (DW),
    .RESET_VAL (RV)
`ifdef PIPE_SKID_STATS_EN
    ,
    .CNT_W     (CW)
`endif
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .flush_i     (flush_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .in_data_i   (in_data_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o)
`ifdef PIPE_SKID_STATS_EN
    ,
    .stall_cnt_o (stall_cnt_o),
    .flush_cnt_o (flush_cnt_o)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the occupancy model, compare all outputs.
  task automatic tick(input logic r, input logic f, input logic v, input logic [DW-1:0] d,
                      input logic ordy);
    bit inf, outf, busy;
    rst = r; flush_i = f; in_valid_i = v; in_data_i = d; out_ready_i = ordy;
    busy = (q.size() > 0);
    inf  = v && (q.size() < 2);
    outf = busy && ordy;
    @(posedge clk);
    #1;
    if (r) begin
      q.delete();
      head_m = RV; stall_m = 0; flush_m = 0;
    end else begin
      if (busy && !ordy && stall_m < CNT_MAX) stall_m++;
      if (f && busy && flush_m < CNT_MAX) flush_m++;
      if (f) begin
        q.delete();
        head_m = RV;
      end else begin
        if (outf) void'(q.pop_front());
        if (inf) q.push_back(d);
        if (q.size() > 0) head_m = q[0];
      end
    end
    chk("out_valid", {31'd0, out_valid_o}, {31'd0, q.size() > 0});
    chk("in_ready", {31'd0, in_ready_o}, {31'd0, q.size() < 2});
    chk("out_data", out_data_o, head_m);
`ifdef PIPE_SKID_STATS_EN
    chk("stall_cnt", {28'd0, stall_cnt_o}, stall_m);
    chk("flush_cnt", {28'd0, flush_cnt_o}, flush_m);
`endif
  endtask

  initial begin
    logic [DW-1:0] d;
    logic v;

    // Reset held two cycles with a beat offered
    tick(1, 0, 1, 32'h11111111, 1);
    tick(1, 0, 1, 32'h22222222, 1);
    chk("reset_data", out_data_o, RV);
    chk("reset_ready", {31'd0, in_ready_o}, 32'd1);

    // Back-to-back streaming
    for (int i = 0; i < 8; i++) begin
      tick(0, 0, 1, 32'hA0 + i, 1);
      chk("stream_data", out_data_o, 32'hA0 + i);
      chk("stream_ready", {31'd0, in_ready_o}, 32'd1);
    end
    tick(0, 0, 0, 'x, 1);

    // Backpressure into skid
    tick(0, 0, 1, 32'hABCDEF01, 0);
    tick(0, 0, 1, 32'h12345678, 0);
    chk("bp_full_ready", {31'd0, in_ready_o}, 32'd0);
    tick(0, 0, 1, 32'h33333333, 0);
    chk("bp_hold_data", out_data_o, 32'hABCDEF01);
    tick(0, 0, 0, 'x, 1);
    chk("bp_second", out_data_o, 32'h12345678);
    tick(0, 0, 0, 'x, 1);
    chk("bp_drained", {31'd0, out_valid_o}, 32'd0);

    // Flush while FULL with a beat offered
    tick(0, 0, 1, 32'h44444444, 0);
    tick(0, 0, 1, 32'h55555555, 0);
    tick(0, 1, 1, 32'hAABBCCDD, 0);
    chk("flush_data", out_data_o, RV);
    chk("flush_ready", {31'd0, in_ready_o}, 32'd1);
    tick(0, 0, 0, 'x, 1);
    chk("flush_squashed", {31'd0, out_valid_o}, 32'd0);

    // Flush and reset together mid-stream
    tick(0, 0, 1, 32'h66666666, 1);
    tick(0, 0, 1, 32'h77777777, 0);
    tick(1, 1, 1, 32'h88888888, 1);
    chk("rstflush_data", out_data_o, RV);
    chk("rstflush_valid", {31'd0, out_valid_o}, 32'd0);

    // Statistics sequence
    tick(1, 0, 0, 'x, 0);
    tick(0, 0, 1, 32'hC0, 0);
    for (int i = 0; i < 5; i++) tick(0, 0, 0, 'x, 0);
    tick(0, 1, 0, 'x, 1);
    tick(0, 0, 1, 32'hC1, 1);
    tick(0, 1, 0, 'x, 1);
    tick(0, 1, 0, 'x, 1);
`ifdef PIPE_SKID_STATS_EN
    chk("stats_stall5", {28'd0, stall_cnt_o}, 32'd5);
    chk("stats_flush2", {28'd0, flush_cnt_o}, 32'd2);
`endif
    tick(0, 0, 1, 32'hC2, 0);
    for (int i = 0; i < 20; i++) tick(0, 0, 0, 'x, 0);
`ifdef PIPE_SKID_STATS_EN
    chk("stats_sat", {28'd0, stall_cnt_o}, 32'd15);
`endif
    tick(0, 1, 0, 'x, 1);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      v = ($urandom_range(0, 3) != 0);
      d = v ? $urandom : 'x;
      tick(($urandom_range(0, 99) == 0), ($urandom_range(0, 31) == 0), v, d,
           ($urandom_range(0, 2) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
